core_mul: RTL and testbench

CORE_MUL -- requirements
Module: core_mul

---
 rtl/core_mul_pkg.sv | 26 ++
 rtl/core_mul_if.sv | 32 +++
 rtl/core_mul_acc.sv | 16 +
 rtl/core_mul.sv | 139 +++++++++++++
 tb/tb_core_mul.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_mul_pkg.sv
// rtl/core_mul_pkg.sv - shared types and constants for the iterative multiplier
package core_mul_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_FIX,
      S_DONE
   } core_mul_state;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } psr_flags;

   localparam int CORE_MUL_W      = 32;
   localparam int CORE_MUL_CYCLES = CORE_MUL_W + 2;

   // Latency for a non-default operand width.
   function automatic int core_mul_cycles(input int w);
      return w + 2;
   endfunction

endpackage

// File: rtl/core_mul_if.sv
// rtl/core_mul_if.sv - request/result bundle between a core and core_mul
interface core_mul_if
   import core_mul_pkg::*;
#(
   parameter int W = 32
);
   logic         start;
   logic         signed_mul;
   logic         long_mul;
   logic         acc;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] c_hi;
   logic [W-1:0] c_lo;
   logic         c_in;
   logic         v_in;
   logic [W-1:0] q_hi;
   logic [W-1:0] q_lo;
   psr_flags     nzcv;
   logic         ready;
   logic         valid;

   modport master (
      output start, signed_mul, long_mul, acc, a, b, c_hi, c_lo, c_in, v_in,
      input  q_hi, q_lo, nzcv, ready, valid
   );

   modport slave (
      input  start, signed_mul, long_mul, acc, a, b, c_hi, c_lo, c_in, v_in,
      output q_hi, q_lo, nzcv, ready, valid
   );
endinterface

// File: rtl/core_mul_acc.sv
// rtl/core_mul_acc.sv - conditional negate of the magnitude product plus accumulator add
module core_mul_acc #(
   parameter int PW = 64
) (
   input  logic [PW-1:0] i_prod,
   input  logic          i_neg,
   input  logic          i_add,
   input  logic [PW-1:0] i_addend,
   output logic [PW-1:0] o_sum
);
   logic [PW-1:0] w_signed;

   assign w_signed = i_neg ? (~i_prod + PW'(1)) : i_prod;
   // Wraps modulo 2^PW; carry out is intentionally dropped.
   assign o_sum    = w_signed + (i_add ? i_addend : '0);
endmodule

// File: rtl/core_mul.sv
// rtl/core_mul.sv - radix-2 shift-add multiplier with accumulate (long results need CORE_MUL_LONG_EN)
module core_mul
   import core_mul_pkg::*;
#(
   parameter int W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   core_mul_if.slave  bus
);
`ifdef CORE_MUL_LONG_EN
   localparam int PW = 2 * W;
`else
   localparam int PW = W;
`endif
   localparam int CW = $clog2(W);

   core_mul_state r_state;
   logic [CW-1:0] r_cnt;
   logic [PW-1:0] r_prod;
   logic [PW-1:0] r_mcand;
   logic [W-1:0]  r_mplier;
   logic [PW-1:0] r_addend;
   logic          r_neg;
   logic          r_acc;
   logic          r_c_flag;
   logic          r_v_flag;
   logic          r_ready;
   logic          r_valid;
   logic [W-1:0]  r_q_lo;
   psr_flags      r_nzcv;
   logic [W-1:0]  w_mag_a;
   logic [W-1:0]  w_mag_b;
   logic [PW-1:0] w_sum;

   // Signed operands are multiplied as magnitudes; the sign is reapplied in FIX.
   assign w_mag_a = (bus.signed_mul && bus.a[W-1]) ? (~bus.a + W'(1)) : bus.a;
   assign w_mag_b = (bus.signed_mul && bus.b[W-1]) ? (~bus.b + W'(1)) : bus.b;

   core_mul_acc #(.PW(PW)) u_acc (
      .i_prod   (r_prod),
      .i_neg    (r_neg),
      .i_add    (r_acc),
      .i_addend (r_addend),
      .o_sum    (w_sum)
   );

`ifdef CORE_MUL_LONG_EN
   logic          r_long;
   logic [W-1:0]  r_q_hi;
   assign bus.q_hi = r_q_hi;
`else
   logic w_unused_long;
   assign w_unused_long = ^{bus.c_hi, bus.long_mul};
   assign bus.q_hi      = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_addend <= '0;
         r_neg    <= 1'b0;
         r_acc    <= 1'b0;
         r_c_flag <= 1'b0;
         r_v_flag <= 1'b0;
         r_ready  <= 1'b1;
         r_valid  <= 1'b0;
         r_q_lo   <= '0;
         r_nzcv   <= '0;
`ifdef CORE_MUL_LONG_EN
         r_long   <= 1'b0;
         r_q_hi   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_valid <= 1'b0;
               if (bus.start) begin
                  r_state  <= S_MUL;
                  r_ready  <= 1'b0;
                  r_cnt    <= CW'(W - 1);
                  r_prod   <= '0;
                  r_mcand  <= PW'(w_mag_a);
                  r_mplier <= w_mag_b;
                  r_neg    <= bus.signed_mul & (bus.a[W-1] ^ bus.b[W-1]);
                  r_acc    <= bus.acc;
                  r_c_flag <= bus.c_in;
                  r_v_flag <= bus.v_in;
`ifdef CORE_MUL_LONG_EN
                  r_long   <= bus.long_mul;
                  r_addend <= {bus.long_mul ? bus.c_hi : W'(0), bus.c_lo};
`else
                  r_addend <= bus.c_lo;
`endif
               end else begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end
            end
            S_MUL: begin
               if (r_mplier[0])
                  r_prod <= r_prod + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               if (r_cnt == '0)
                  r_state <= S_FIX;
               else
                  r_cnt <= r_cnt - CW'(1);
            end
            S_FIX: begin
               r_state  <= S_DONE;
               r_ready  <= 1'b1;
               r_valid  <= 1'b1;
               r_q_lo   <= w_sum[W-1:0];
               r_nzcv.c <= r_c_flag;
               r_nzcv.v <= r_v_flag;
`ifdef CORE_MUL_LONG_EN
               r_q_hi   <= r_long ? w_sum[2*W-1:W] : W'(0);
               r_nzcv.n <= r_long ? w_sum[2*W-1] : w_sum[W-1];
               r_nzcv.z <= r_long ? (w_sum == '0) : (w_sum[W-1:0] == '0);
`else
               r_nzcv.n <= w_sum[W-1];
               r_nzcv.z <= (w_sum == '0);
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.q_lo  = r_q_lo;
   assign bus.nzcv  = r_nzcv;
   assign bus.ready = r_ready;
   assign bus.valid = r_valid;
endmodule

// File: tb/tb_core_mul.sv
// tb/tb_core_mul.sv - self-checking bench for core_mul against an arithmetic reference model
module tb_core_mul;
   import core_mul_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic        sgn;
      logic        lng;
      logic        ac;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] chi;
      logic [31:0] clo;
      logic        cin;
      logic        vin;
   } op_t;

   typedef struct {
      int          cyc;
      logic [31:0] qhi;
      logic [31:0] qlo;
      logic [3:0]  f;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q[$];
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;
   logic [3:0]  last_f = '0;

   core_mul_if #(.W(W)) bus ();

   core_mul #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Reference: full-precision integer product, then the visible slice.
   function automatic exp_t model(input op_t o);
      exp_t        e;
      logic [63:0] p;
      logic [63:0] r;
      logic        lng;
      longint      sa;
      longint      sb;
`ifdef CORE_MUL_LONG_EN
      lng = o.lng;
`else
      lng = 1'b0;
`endif
      if (o.sgn) begin
         sa = longint'($signed(o.a));
         sb = longint'($signed(o.b));
         p  = 64'(sa * sb);
      end else begin
         p = {32'd0, o.a} * {32'd0, o.b};
      end
      r = p + (o.ac ? {lng ? o.chi : 32'd0, o.clo} : 64'd0);
      e.cyc = 0;
      e.qlo = r[31:0];
      e.qhi = lng ? r[63:32] : 32'd0;
      e.f   = {lng ? r[63] : r[31], lng ? (r == 64'd0) : (r[31:0] == 32'd0), o.cin, o.vin};
      return e;
   endfunction

   function automatic op_t mk(input logic sgn, lng, ac, input logic [31:0] a, b, chi, clo,
                              input logic cin, vin);
      op_t o;
      o.sgn = sgn; o.lng = lng; o.ac = ac; o.a = a; o.b = b;
      o.chi = chi; o.clo = clo; o.cin = cin; o.vin = vin;
      return o;
   endfunction

   task automatic pin(input string nm, input op_t o, input logic [63:0] rq, input logic [3:0] rf);
      exp_t e;
      e = model(o);
      chk({nm, "_q"}, {e.qhi, e.qlo}, rq);
      chk({nm, "_f"}, {60'd0, e.f}, {60'd0, rf});
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("ready", {63'd0, bus.ready}, {63'd0, bus.valid || q.size() == 0});
         if (bus.valid) begin
            if (q.size() == 0) begin
               chk("valid_unexpected", {63'd0, bus.valid}, 64'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("valid_cycle", 64'(cyc), 64'(e.cyc));
               chk("q_hi", {32'd0, bus.q_hi}, {32'd0, e.qhi});
               chk("q_lo", {32'd0, bus.q_lo}, {32'd0, e.qlo});
               chk("nzcv", {60'd0, bus.nzcv}, {60'd0, e.f});
               last_hi = e.qhi;
               last_lo = e.qlo;
               last_f  = e.f;
            end
         end else begin
            chk("hold", {bus.q_hi, bus.q_lo}, {last_hi, last_lo});
            chk("hold_nzcv", {60'd0, bus.nzcv}, {60'd0, last_f});
            if (q.size() != 0 && cyc > q[0].cyc) begin
               chk("valid_missing", {63'd0, bus.valid}, 64'd1);
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic issue(input op_t o);
      exp_t e;
      bus.signed_mul = o.sgn; bus.long_mul = o.lng; bus.acc = o.ac;
      bus.a = o.a; bus.b = o.b; bus.c_hi = o.chi; bus.c_lo = o.clo;
      bus.c_in = o.cin; bus.v_in = o.vin; bus.start = 1'b1;
      @(posedge clk);
      #1;
      e = model(o);
      e.cyc = cyc + CORE_MUL_CYCLES - 1;
      q.push_back(e);
      bus.start = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!bus.ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", {63'd0, bus.ready}, 64'd1);
   endtask

   task automatic wait_valid();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.valid && n < 100);
      chk("valid_timeout", {63'd0, bus.valid}, 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   op_t ops[$];

   initial begin
      bus.start = 0; bus.signed_mul = 0; bus.long_mul = 0; bus.acc = 0;
      bus.a = '0; bus.b = '0; bus.c_hi = '0; bus.c_lo = '0; bus.c_in = 0; bus.v_in = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {63'd0, bus.ready}, 64'd1);
      chk("rst_valid", {63'd0, bus.valid}, 64'd0);
      chk("rst_q", {bus.q_hi, bus.q_lo}, 64'd0);
      chk("rst_nzcv", {60'd0, bus.nzcv}, 64'd0);
      rst_n = 1'b1;

      pin("pin_u7x6", mk(0, 0, 0, 32'd7, 32'd6, 0, 0, 0, 0), 64'h0000_0000_0000_002A, 4'b0000);
`ifdef CORE_MUL_LONG_EN
      pin("pin_sl", mk(1, 1, 0, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 0), 64'hFFFF_FFFF_FFFF_FFF1, 4'b1000);
      pin("pin_ul", mk(0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0), 64'hFFFF_FFFE_0000_0001, 4'b1000);
`else
      pin("pin_sl", mk(1, 1, 0, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 0), 64'h0000_0000_FFFF_FFF1, 4'b1000);
      pin("pin_ul", mk(0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0), 64'h0000_0000_0000_0001, 4'b0000);
`endif
      pin("pin_mla", mk(0, 0, 1, 32'hFFFF_FFFF, 32'd2, 0, 32'd3, 0, 0), 64'h0000_0000_0000_0001, 4'b0000);
      pin("pin_zero", mk(0, 0, 0, 32'd0, 32'h1234, 0, 0, 1, 0), 64'd0, 4'b0110);

      ops.push_back(mk(0, 0, 0, 32'd7, 32'd6, 0, 0, 0, 0));
      ops.push_back(mk(1, 1, 0, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 1));
      ops.push_back(mk(0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0));
      ops.push_back(mk(0, 0, 1, 32'hFFFF_FFFF, 32'd2, 32'hAAAA_0000, 32'd3, 1, 1));
      ops.push_back(mk(0, 0, 0, 32'd0, 32'h1234, 0, 0, 1, 0));
      ops.push_back(mk(1, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0));
      ops.push_back(mk(1, 1, 1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 0, 0));
      ops.push_back(mk(0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0));
      ops.push_back(mk(0, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h5555_5555, 32'h7777_7777, 0, 1));
      ops.push_back(mk(1, 0, 1, 32'hFFFF_FFFD, 32'd5, 32'h55, 32'h10, 0, 0));
      ops.push_back(mk(1, 0, 0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 1, 1));
      foreach (ops[i]) begin
         wait_ready();
         issue(ops[i]);
         drain();
      end

      // start held high (with garbage operands) while the multiply is in flight
      wait_ready();
      issue(mk(1, 1, 1, 32'hFFFF_FF00, 32'h0000_0123, 32'd7, 32'd9, 1, 1));
      repeat (20) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.a = $urandom; bus.b = $urandom; bus.acc = 1'($urandom); bus.signed_mul = 1'($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
      drain();

      // back-to-back: second start lands in the DONE cycle
      wait_ready();
      issue(mk(0, 0, 0, 32'd100, 32'd3, 0, 0, 0, 0));
      wait_valid();
      issue(mk(1, 1, 0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, 0, 1, 0));
      drain();

      // reset mid-MUL aborts the operation
      wait_ready();
      issue(mk(0, 1, 0, 32'hDEAD_BEEF, 32'h0000_0011, 0, 0, 1, 1));
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_ready", {63'd0, bus.ready}, 64'd1);
      chk("abort_valid", {63'd0, bus.valid}, 64'd0);
      chk("abort_q", {bus.q_hi, bus.q_lo}, 64'd0);
      chk("abort_nzcv", {60'd0, bus.nzcv}, 64'd0);
      q.delete();
      last_hi = '0; last_lo = '0; last_f = '0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(negedge clk);

      wait_ready();
      issue(mk(0, 0, 0, 32'd9, 32'd9, 0, 0, 0, 1));
      drain();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
